// File: rtl/cla_decomposed_subtractor_if.sv
// Valid/ready stream bundle for cla_decomposed_subtractor.
// chk_err is present only when CLA_SUB_CHECK_EN is defined.
interface cla_decomposed_subtractor_if #(
  parameter int NBIT = 7
);
  logic            in_valid;
  logic            in_ready;
  logic [NBIT-1:0] in_s;
  logic [NBIT-1:0] in_a;
  logic            out_valid;
  logic            out_ready;
  logic [NBIT-1:0] out_b;
  logic            out_borrow;
`ifdef CLA_SUB_CHECK_EN
  logic            chk_err;

  modport master (
    output in_valid, in_s, in_a, out_ready,
    input  in_ready, out_valid, out_b,
    input  out_borrow, chk_err
  );

  modport slave (
    input  in_valid, in_s, in_a, out_ready,
    output in_ready, out_valid, out_b,
    output out_borrow, chk_err
  );
`else
  modport master (
    output in_valid, in_s, in_a, out_ready,
    input  in_ready, out_valid, out_b,
    input  out_borrow
  );

  modport slave (
    input  in_valid, in_s, in_a, out_ready,
    output in_ready, out_valid, out_b,
    output out_borrow
  );
`endif
endinterface

// File: rtl/cla_decomposed_subtractor.sv
// Two-stage CLA subtractor b = (s - a) mod 2^NBIT, carry net then XOR.
// Optional self-check of a + b == s enabled by CLA_SUB_CHECK_EN.
module cla_decomposed_subtractor #(
  parameter int NBIT = 7
) (
  input logic                       clk,
  input logic                       rst_n,
  cla_decomposed_subtractor_if.slave bus
);

  typedef struct packed {
    logic [NBIT-1:0] p;
    logic [NBIT-1:0] c;
    logic            cout;
`ifdef CLA_SUB_CHECK_EN
    logic [NBIT-1:0] s;
    logic [NBIT-1:0] a;
`endif
  } s1_t;

  logic [NBIT-1:0] t;
  logic [NBIT-1:0] g;
  logic [NBIT-1:0] p;
  logic [NBIT:0]   c;

  s1_t             s1_q;
  logic            s1_valid;
  logic            out_valid_q;
  logic [NBIT-1:0] out_b_q;
  logic            out_borrow_q;

  logic            s2_adv;
  logic            in_ready;
  logic            accept;

  assign t = ~bus.in_a;
  assign g = bus.in_s & t;
  assign p = bus.in_s ^ t;

  // Each carry is a flat sum of products over g/p, no ripple chain.
  always_comb begin
    logic term;
    logic acc;
    c    = '0;
    c[0] = 1'b1;
    term = 1'b0;
    acc  = 1'b0;
    for (int i = 0; i < NBIT; i++) begin
      term = 1'b1;
      for (int k = 0; k <= i; k++) begin
        term = term & p[k];
      end
      acc = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) begin
          term = term & p[k];
        end
        acc = acc | term;
      end
      c[i+1] = acc;
    end
  end

  assign s2_adv   = s1_valid & (~out_valid_q | bus.out_ready);
  assign in_ready = ~s1_valid | s2_adv;
  assign accept   = bus.in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_q.p    <= p;
      s1_q.c    <= c[NBIT-1:0];
      s1_q.cout <= c[NBIT];
`ifdef CLA_SUB_CHECK_EN
      s1_q.s    <= bus.in_s;
      s1_q.a    <= bus.in_a;
`endif
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_b_q      <= '0;
      out_borrow_q <= 1'b0;
    end else if (s2_adv) begin
      out_valid_q  <= 1'b1;
      out_b_q      <= s1_q.p ^ s1_q.c;
      out_borrow_q <= ~s1_q.cout;
    end else if (bus.out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

`ifdef CLA_SUB_CHECK_EN
  logic [NBIT-1:0] s2_s;
  logic [NBIT-1:0] s2_a;
  logic [NBIT-1:0] chk_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_s <= '0;
      s2_a <= '0;
    end else if (s2_adv) begin
      s2_s <= s1_q.s;
      s2_a <= s1_q.a;
    end
  end

  assign chk_sum     = s2_a + out_b_q;
  assign bus.chk_err = out_valid_q & (chk_sum != s2_s);
`endif

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_b      = out_b_q;
  assign bus.out_borrow = out_borrow_q;

endmodule
